mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/rr_arb2.sv | 15 +
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner types and default widths for the memory arbiter
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_MASK_W = 8;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; index 0 is fetch, index 1 is load/store
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_d;
    always_comb gnt = (&req) ? (last_d ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk) begin
        if (rst) last_d <= 1'b1;
        else if (advance && (|gnt)) last_d <= gnt[1];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, one transaction in flight
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MASK_W = DEF_MASK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [MASK_W-1:0] d_req_wmask,
    input  logic              d_req_wen,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    output logic              mem_req_wen,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);
    state_t state, state_n;
    owner_t own_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic wen_q, resp_q, done, idle_ok;
    logic [1:0] gnt;
    assign idle_ok = (state == IDLE) && !rst;
    rr_arb2 u_rr (
        .clk(clk),
        .rst(rst),
        .req({d_req_valid, i_req_valid} & {2{idle_ok}}),
        .advance(idle_ok),
        .gnt(gnt)
    );
    assign i_req_ready = gnt[0];
    assign d_req_ready = gnt[1];
    always_comb begin
        done    = ((state == REQ && mem_req_ready) || state == WAIT) && mem_resp_valid;
        state_n = done ? IDLE :
                  state == IDLE ? ((|gnt) ? REQ : IDLE) :
                  state == REQ  ? (mem_req_ready ? WAIT : REQ) : WAIT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            own_q   <= OWN_I;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            wen_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state  <= state_n;
            resp_q <= done;
            if (done) rdata_q <= mem_resp_rdata;
            if (gnt[0]) begin
                addr_q  <= i_req_addr;
                wdata_q <= '0;
                wmask_q <= '0;
                wen_q   <= 1'b0;
                own_q   <= OWN_I;
            end else if (gnt[1]) begin
                addr_q  <= d_req_addr;
                wdata_q <= d_req_wdata;
                wmask_q <= d_req_wmask;
                wen_q   <= d_req_wen;
                own_q   <= OWN_D;
            end
        end
    end
    // own_q is only overwritten at the end of the pulse cycle, so it still names the responder
    assign mem_req_valid = (state == REQ) && !rst;
    assign mem_req_addr  = rst ? '0 : addr_q;
    assign mem_req_wdata = rst ? '0 : wdata_q;
    assign mem_req_wmask = rst ? '0 : wmask_q;
    assign mem_req_wen   = !rst && wen_q;
    assign i_resp_valid  = resp_q && own_q == OWN_I && !rst;
    assign d_resp_valid  = resp_q && own_q == OWN_D && !rst;
    assign i_resp_rdata  = rst ? '0 : rdata_q;
    assign d_resp_rdata  = rst ? '0 : rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-queue model
module tb_mem_arbiter;
    logic clk = 1'b0, rst;
    logic i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_req_addr, i_resp_rdata;
    logic d_req_valid, d_req_ready, d_req_wen, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
    logic [7:0] d_req_wmask, mem_req_wmask;
    logic mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    typedef struct {logic d; logic [31:0] a; logic [31:0] wd; logic [7:0] wm; logic we;} req_t;
    typedef struct {logic d; logic [31:0] rd; logic we;} rsp_t;
    req_t req_q[$];
    rsp_t rsp_q[$];
    int tests = 0, fails = 0, n_resp = 0;
    bit last_d = 1'b1;
    always #5 clk = ~clk;
    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask), .d_req_wen(d_req_wen),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_wen(mem_req_wen),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic rst_check(input string tag);
        chk({tag, "_i_ready"}, i_req_ready, 0);
        chk({tag, "_d_ready"}, d_req_ready, 0);
        chk({tag, "_mreq_valid"}, mem_req_valid, 0);
        chk({tag, "_mreq_fields"}, {mem_req_addr, mem_req_wdata}, 0);
        chk({tag, "_mreq_mask_wen"}, {mem_req_wmask, mem_req_wen}, 0);
        chk({tag, "_resp_valid"}, {i_resp_valid, d_resp_valid}, 0);
        chk({tag, "_resp_rdata"}, {i_resp_rdata, d_resp_rdata}, 0);
    endtask
    task automatic idle_check(input string tag);
        mid();
        chk({tag, "_mreq_valid"}, mem_req_valid, 0);
        chk({tag, "_resp_valid"}, {i_resp_valid, d_resp_valid}, 0);
        step();
    endtask
    // model of one arbitration decision in an idle cycle: tie goes to whoever did not win last
    task automatic accept_check();
        bit iv = i_req_valid, dv = d_req_valid, wd;
        req_t r;
        wd = dv && !(iv && last_d);
        chk("i_req_ready", i_req_ready, iv && !wd);
        chk("d_req_ready", d_req_ready, wd);
        if (iv || dv) begin
            last_d = wd;
            r.d  = wd;
            r.a  = wd ? d_req_addr : i_req_addr;
            r.wd = wd ? d_req_wdata : 32'h0;
            r.wm = wd ? d_req_wmask : 8'h0;
            r.we = wd ? d_req_wen : 1'b0;
            req_q.push_back(r);
        end
    endtask
    task automatic fields(input req_t r);
        chk("mreq_valid", mem_req_valid, 1);
        chk("mreq_addr", mem_req_addr, r.a);
        chk("mreq_wdata", mem_req_wdata, r.wd);
        chk("mreq_wmask", mem_req_wmask, r.wm);
        chk("mreq_wen", mem_req_wen, r.we);
        chk("busy_ready", {i_req_ready, d_req_ready}, 0);
    endtask
    // entered the cycle after an accept; returns at the negedge of the response pulse cycle
    task automatic serve(input int wait_n, input bit zl, input logic [31:0] rd, input bit noise);
        req_t r;
        rsp_t e;
        if (req_q.size() == 0) begin
            chk("req_queue_empty", 1, 0);
            return;
        end
        r = req_q.pop_front();
        for (int k = 0; k < wait_n; k++) begin
            mem_req_ready = 1'b0;
            if (noise) begin
                mem_resp_valid = 1'($urandom);
                mem_resp_rdata = $urandom;
                i_req_valid    = 1'($urandom);
                i_req_addr     = $urandom;
            end
            mid();
            fields(r);
            chk("wait_resp_valid", {i_resp_valid, d_resp_valid}, 0);
            step();
        end
        if (noise) i_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = zl;
        mem_resp_rdata = zl ? rd : $urandom;
        mid();
        fields(r);
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        if (!zl) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rd;
            mid();
            chk("wait_mreq_valid", mem_req_valid, 0);
            chk("wait_resp_valid", {i_resp_valid, d_resp_valid}, 0);
            step();
            mem_resp_valid = 1'b0;
        end
        rsp_q.push_back('{d: r.d, rd: rd, we: r.we});
        mid();
        e = rsp_q.pop_front();
        n_resp++;
        chk("i_resp_valid", i_resp_valid, !e.d);
        chk("d_resp_valid", d_resp_valid, e.d);
        if (!e.we) chk(e.d ? "d_resp_rdata" : "i_resp_rdata", e.d ? d_resp_rdata : i_resp_rdata, e.rd);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        last_d = 1'b1;
        req_q.delete();
        rsp_q.delete();
    endtask
    task automatic rand_d();
        d_req_addr  = $urandom;
        d_req_wdata = $urandom;
        d_req_wmask = 8'($urandom);
        d_req_wen   = 1'($urandom);
    endtask
    initial begin
        int base;
        i_req_valid = 1'b1; i_req_addr = 32'h1;
        d_req_valid = 1'b1; d_req_addr = 32'h2; d_req_wdata = 32'h3; d_req_wmask = 8'hff; d_req_wen = 1'b1;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
        do_reset();
        step();
        mid();
        rst_check("reset");
        step();
        rst = 1'b0; d_req_valid = 1'b0;
        i_req_addr = 32'h8000_0000;
        mid();
        accept_check();
        step();
        i_req_valid = 1'b0;
        serve(0, 1'b0, 32'h0010_0073, 1'b0);
        accept_check();
        step();
        idle_check("after_fetch");
        do_reset();
        step();
        rst = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0004;
        d_req_valid = 1'b1; d_req_addr = 32'h8000_1000; d_req_wen = 1'b0; d_req_wdata = 32'h0; d_req_wmask = 8'h0;
        mid();
        accept_check();
        step();
        i_req_valid = 1'b0;
        serve(1, 1'b0, 32'h1111_1111, 1'b0);
        accept_check();
        step();
        d_req_valid = 1'b0;
        serve(0, 1'b0, 32'h2222_2222, 1'b0);
        accept_check();
        step();
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0008;
        mid();
        accept_check();
        step();
        i_req_valid = 1'b0;
        serve(0, 1'b0, 32'h3333_3333, 1'b0);
        accept_check();
        step();
        i_req_valid = 1'b1; i_req_addr = 32'h8000_000c;
        d_req_valid = 1'b1; d_req_addr = 32'h8000_1004;
        mid();
        accept_check();
        step();
        d_req_valid = 1'b0;
        serve(0, 1'b0, 32'h4444_4444, 1'b0);
        accept_check();
        step();
        i_req_valid = 1'b0;
        serve(0, 1'b0, 32'h5555_5555, 1'b0);
        accept_check();
        step();
        d_req_valid = 1'b1; d_req_addr = 32'h8000_2000; d_req_wdata = 32'hdead_beef; d_req_wmask = 8'h0f; d_req_wen = 1'b1;
        mid();
        accept_check();
        step();
        d_req_valid = 1'b0;
        serve(3, 1'b0, 32'h6666_6666, 1'b1);
        accept_check();
        step();
        idle_check("after_store");
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0010;
        mid();
        accept_check();
        step();
        i_req_valid = 1'b0;
        serve(0, 1'b1, 32'h1234_5678, 1'b0);
        accept_check();
        step();
        idle_check("after_zero_lat");
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hbad0_bad0;
        idle_check("stray_resp");
        mem_resp_valid = 1'b0;
        idle_check("after_stray");
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0014;
        mid();
        accept_check();
        step();
        i_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        do_reset();
        i_req_valid = 1'b1; d_req_valid = 1'b1; mem_resp_valid = 1'b1;
        mid();
        rst_check("mid_rst");
        step();
        rst = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;
        mem_resp_rdata = 32'hfeed_f00d;
        idle_check("late_resp");
        mem_resp_valid = 1'b0;
        idle_check("after_late_resp");
        i_req_valid = 1'b1; i_req_addr = 32'h8000_0018;
        mid();
        accept_check();
        step();
        i_req_valid = 1'b0;
        serve(0, 1'b0, 32'h7777_7777, 1'b0);
        accept_check();
        step();
        base = n_resp;
        d_req_valid = 1'b1;
        rand_d();
        mid();
        accept_check();
        step();
        for (int k = 0; k < 100; k++) begin
            rand_d();
            if (k == 99) d_req_valid = 1'b0;
            serve(int'($urandom_range(0, 2)), 1'($urandom), $urandom, 1'b0);
            accept_check();
            step();
        end
        chk("rand_resp_count", n_resp - base, 100);
        chk("rand_queues_empty", req_q.size() + rsp_q.size(), 0);
        idle_check("final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
